step_sequencer: RTL and testbench

- Parametrised control-step FSM that drives the datapath's enable, select, ALU-op and register-address lines.
- Runs fetch (T0–T2) plus an opcode-dependent execute sequence (T3–T6), replacing hand-sequenced control steps in benches and top level.
- Adds a memory-read handshake with timeout, multi-destination writeback (HI/LO), and halt/fault states.

---
 rtl/step_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_step_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : step_sequencer
//  Purpose  : Control-step FSM for the datapath. Runs fetch (T0-T2) with a
//             memory-read handshake and timeout, then an opcode-dependent
//             execute sequence (T3-T6). HALT and FAULT are sticky until reset.
//  Options  : define STEP_TRACE_EN to add trace_state and instr_count outputs.
//  Revision : 1.0  initial release
// ============================================================================
module step_sequencer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int ALU_OP_W   = 4,
  parameter int SEL_W      = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  run,
  input  logic [DATA_W-1:0]     ir,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  e_PC,
  output logic                  e_IR,
  output logic                  e_Y,
  output logic                  e_Z,
  output logic                  e_HI,
  output logic                  e_LO,
  output logic                  e_MDR,
  output logic                  e_MAR,
  output logic                  e_GP,
  output logic                  incPC,
  output logic                  MDR_read,
  output logic [SEL_W-1:0]      BusDataSelect,
  output logic [REG_ADDR_W-1:0] GP_addr,
  output logic [ALU_OP_W-1:0]   ALU_op,
  output logic                  instr_done,
  output logic                  halted,
  output logic                  fault
`ifdef STEP_TRACE_EN
  ,
  output logic [3:0]            trace_state,
  output logic [15:0]           instr_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [SEL_W-1:0] c_SEL_ZHI  = SEL_W'(18);
  localparam logic [SEL_W-1:0] c_SEL_ZLO  = SEL_W'(19);
  localparam logic [SEL_W-1:0] c_SEL_PC   = SEL_W'(20);
  localparam logic [SEL_W-1:0] c_SEL_MDR  = SEL_W'(21);
  localparam logic [SEL_W-1:0] c_SEL_IMM  = SEL_W'(22);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction fields; only meaningful from T3 on, once IR has been loaded.
  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_ra        = ir[26:23];
  assign w_rb        = ir[22:19];
  assign w_rc        = ir[18:15];
  assign w_unused_ir = ^ir;

  // State register and T1 wait counter; reset abandons any instruction in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control-line decode from the registered step and IR.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req       = 1'b0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    BusDataSelect = '0;
    GP_addr       = '0;
    ALU_op        = '0;
    instr_done    = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        BusDataSelect = c_SEL_PC;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        e_Z           = 1'b1;
        cnt_d         = '0;
        state_d       = S_T1;
      end
      S_T1: begin
        mem_req = 1'b1;
        // PC picks up PC+1 from Zlo only on the first wait cycle.
        if (cnt_q == '0) begin
          BusDataSelect = c_SEL_ZLO;
          e_PC          = 1'b1;
        end
        if (mem_ack) begin
          MDR_read = 1'b1;
          e_MDR    = 1'b1;
          cnt_d    = '0;
          state_d  = S_T2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == c_CNT_MAX) state_d = S_FAULT;
        end
      end
      S_T2: begin
        BusDataSelect = c_SEL_MDR;
        e_IR          = 1'b1;
        state_d       = S_T3;
      end
      S_T3: begin
        if (w_op <= 5'd10 || w_op == 5'd15) begin
          BusDataSelect = SEL_W'(w_rb);
          e_Y           = 1'b1;
          state_d       = S_T4;
        end else if (w_op <= 5'd12) begin
          BusDataSelect = SEL_W'(w_rb);
          ALU_op        = ALU_OP_W'(w_op[3:0]);
          e_Z           = 1'b1;
          state_d       = S_T4;
        end else if (w_op <= 5'd14) begin
          BusDataSelect = SEL_W'(w_ra);
          e_Y           = 1'b1;
          state_d       = S_T4;
        end else if (w_op == 5'd31) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T4: begin
        if (w_op <= 5'd10) begin
          BusDataSelect = SEL_W'(w_rc);
          ALU_op        = ALU_OP_W'(w_op[3:0]);
          e_Z           = 1'b1;
          state_d       = S_T5;
        end else if (w_op <= 5'd12) begin
          BusDataSelect = c_SEL_ZLO;
          GP_addr       = REG_ADDR_W'(w_ra);
          e_GP          = 1'b1;
          instr_done    = 1'b1;
        end else if (w_op <= 5'd14) begin
          BusDataSelect = SEL_W'(w_rb);
          ALU_op        = ALU_OP_W'(w_op[3:0]);
          e_Z           = 1'b1;
          state_d       = S_T5;
        end else if (w_op == 5'd15) begin
          BusDataSelect = c_SEL_IMM;
          e_Z           = 1'b1;
          state_d       = S_T5;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T5: begin
        BusDataSelect = c_SEL_ZLO;
        if (w_op == 5'd13 || w_op == 5'd14) begin
          e_LO    = 1'b1;
          state_d = S_T6;
        end else begin
          GP_addr    = REG_ADDR_W'(w_ra);
          e_GP       = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        BusDataSelect = c_SEL_ZHI;
        e_HI          = 1'b1;
        instr_done    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // run is only consulted at instruction boundaries, never mid-instruction.
    if (instr_done) state_d = run ? S_T0 : S_IDLE;
  end

`ifdef STEP_TRACE_EN
  logic [15:0] instr_count_q;

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) instr_count_q <= '0;
    else if (instr_done) instr_count_q <= instr_count_q + 16'd1;
  end

  assign trace_state = state_q;
  assign instr_count = instr_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_sequencer
//  Purpose  : Self-checking bench for step_sequencer. Expected control words
//             are built per instruction from the step tables and compared
//             every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_step_sequencer;

  localparam int TIMEOUT = 15;

  localparam logic [8:0] E_PC  = 9'h100;
  localparam logic [8:0] E_IR  = 9'h080;
  localparam logic [8:0] E_Y   = 9'h040;
  localparam logic [8:0] E_Z   = 9'h020;
  localparam logic [8:0] E_HI  = 9'h010;
  localparam logic [8:0] E_LO  = 9'h008;
  localparam logic [8:0] E_MDR = 9'h004;
  localparam logic [8:0] E_MAR = 9'h002;
  localparam logic [8:0] E_GP  = 9'h001;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_ack;
  logic        mem_req, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
  logic        incPC, MDR_read, instr_done, halted, fault;
  logic [4:0]  BusDataSelect;
  logic [3:0]  GP_addr;
  logic [3:0]  ALU_op;
  logic [27:0] w_ctrl;

  int n_vec = 0;
  int n_err = 0;

  logic [27:0] exp_q[$];
  logic        ack_q[$];
  int          ir_idx;
  bit          terminal;
  bit          in_idle;

  step_sequencer #(
    .DATA_W(32), .REG_ADDR_W(4), .ALU_OP_W(4), .SEL_W(5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ack(mem_ack),
    .mem_req(mem_req), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z),
    .e_HI(e_HI), .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP),
    .incPC(incPC), .MDR_read(MDR_read), .BusDataSelect(BusDataSelect),
    .GP_addr(GP_addr), .ALU_op(ALU_op), .instr_done(instr_done),
    .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  assign w_ctrl = {mem_req, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
                   incPC, MDR_read, BusDataSelect, GP_addr, ALU_op,
                   instr_done, halted, fault};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected normal completion");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] cw(input logic req, input logic [8:0] en, input logic inc,
                                     input logic mdr, input int sel, input int gp, input int alu,
                                     input logic done, input logic hlt, input logic flt);
    return {req, en, inc, mdr, 5'(sel), 4'(gp), 4'(alu), done, hlt, flt};
  endfunction

  // One clock cycle: drive inputs, compare the decoded controls, advance.
  task automatic step(input string tag, input logic [27:0] exp_w, input logic ack_v, input logic run_v);
    mem_ack = ack_v;
    run     = run_v;
    #1;
    check_value(tag, w_ctrl, exp_w);
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [27:0] w, input logic a);
    exp_q.push_back(w);
    ack_q.push_back(a);
  endtask

  // Expected per-cycle control words for one instruction; dly >= TIMEOUT means no ack.
  task automatic build(input int op, input int ra, input int rb, input int rc, input int dly);
    int alu;
    alu = op & 15;
    exp_q.delete();
    ack_q.delete();
    terminal = 0;
    push(cw(0, E_MAR | E_Z, 1, 0, 20, 0, 0, 0, 0, 0), 1'b0);
    if (dly >= TIMEOUT) begin
      for (int k = 0; k < TIMEOUT; k++)
        push(cw(1, (k == 0) ? E_PC : 9'h0, 0, 0, (k == 0) ? 19 : 0, 0, 0, 0, 0, 0), 1'b0);
      for (int k = 0; k < 4; k++) push(cw(0, 9'h0, 0, 0, 0, 0, 0, 0, 0, 1), 1'($urandom));
      terminal = 1;
      ir_idx   = -1;
      return;
    end
    for (int k = 0; k <= dly; k++)
      push(cw(1, ((k == 0) ? E_PC : 9'h0) | ((k == dly) ? E_MDR : 9'h0), 0, (k == dly),
              (k == 0) ? 19 : 0, 0, 0, 0, 0, 0), (k == dly));
    push(cw(0, E_IR, 0, 0, 21, 0, 0, 0, 0, 0), 1'b0);
    ir_idx = exp_q.size() - 1;
    if (op <= 10) begin
      push(cw(0, E_Y,  0, 0, rb, 0,  0,   0, 0, 0), 1'b0);
      push(cw(0, E_Z,  0, 0, rc, 0,  alu, 0, 0, 0), 1'b0);
      push(cw(0, E_GP, 0, 0, 19, ra, 0,   1, 0, 0), 1'b0);
    end else if (op <= 12) begin
      push(cw(0, E_Z,  0, 0, rb, 0,  alu, 0, 0, 0), 1'b0);
      push(cw(0, E_GP, 0, 0, 19, ra, 0,   1, 0, 0), 1'b0);
    end else if (op <= 14) begin
      push(cw(0, E_Y,  0, 0, ra, 0, 0,   0, 0, 0), 1'b0);
      push(cw(0, E_Z,  0, 0, rb, 0, alu, 0, 0, 0), 1'b0);
      push(cw(0, E_LO, 0, 0, 19, 0, 0,   0, 0, 0), 1'b0);
      push(cw(0, E_HI, 0, 0, 18, 0, 0,   1, 0, 0), 1'b0);
    end else if (op == 15) begin
      push(cw(0, E_Y,  0, 0, rb, 0,  0, 0, 0, 0), 1'b0);
      push(cw(0, E_Z,  0, 0, 22, 0,  0, 0, 0, 0), 1'b0);
      push(cw(0, E_GP, 0, 0, 19, ra, 0, 1, 0, 0), 1'b0);
    end else begin
      push('0, 1'b0);
      for (int k = 0; k < 4; k++)
        push(cw(0, 9'h0, 0, 0, 0, 0, 0, 0, (op == 31), (op != 31)), 1'($urandom));
      terminal = 1;
    end
  endtask

  // Assert clear mid-cycle, check controls drop without a clock edge, release.
  task automatic do_reset(input string tag);
    mem_ack = 1'b0;
    run     = 1'b1;
    #1;
    clear = 1'b0;
    #1;
    check_value({tag, "/rst_async"}, w_ctrl, '0);
    @(posedge clock);
    #1;
    check_value({tag, "/rst_hold"}, w_ctrl, '0);
    clear   = 1'b1;
    in_idle = 1;
  endtask

  task automatic run_instr(input string tag, input int op, input int ra, input int rb, input int rc,
                           input int dly, input logic run_end, input int abort_at);
    logic [31:0] new_ir;
    logic        rv;
    if (in_idle) step({tag, "/idle"}, '0, 1'b0, 1'b1);
    in_idle = 0;
    build(op, ra, rb, rc, dly);
    new_ir = {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        mem_ack = ack_q[i];
        run     = 1'b1;
        #1;
        check_value({tag, "/pre_abort"}, w_ctrl, exp_q[i]);
        do_reset(tag);
        return;
      end
      if (terminal) rv = 1'b1;
      else if (i == exp_q.size() - 1) rv = run_end;
      else rv = 1'($urandom);
      step($sformatf("%s/c%0d", tag, i), exp_q[i], ack_q[i], rv);
      if (i == ir_idx) ir = new_ir;
    end
    if (terminal) do_reset(tag);
    else in_idle = !run_end;
  endtask

  initial begin
    int op;
    clear   = 1'b0;
    run     = 1'b0;
    mem_ack = 1'b0;
    ir      = 32'h0;
    in_idle = 1;
    #2;
    check_value("reset_state", w_ctrl, '0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    step("idle_run0", '0, 1'b0, 1'b0);
    step("idle_run0b", '0, 1'b1, 1'b0);

    run_instr("neg",     11, 4, 2, 0, 0, 1'b1, -1);
    run_instr("add",      3, 5, 1, 2, 3, 1'b1, -1);
    run_instr("mul",     13, 7, 9, 0, 1, 1'b0, -1);
    run_instr("addi",    15, 3, 6, 1, 0, 1'b1, -1);
    run_instr("div",     14, 2, 8, 0, 2, 1'b1, -1);
    run_instr("not",     12, 15, 14, 0, 0, 1'b0, -1);
    run_instr("abort_t4", 3, 5, 1, 2, 0, 1'b1, 4);
    run_instr("after_rst", 0, 1, 2, 3, 0, 1'b1, -1);
    run_instr("halt",    31, 0, 0, 0, 0, 1'b1, -1);
    run_instr("op20",    20, 0, 0, 0, 1, 1'b1, -1);
    run_instr("timeout",  1, 0, 0, 0, TIMEOUT, 1'b1, -1);
    run_instr("late_ack", 2, 6, 3, 4, TIMEOUT - 1, 1'b1, -1);

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 15);
      run_instr($sformatf("rnd%0d", n), op, $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 5), 1'($urandom), -1);
    end
    run_instr("rnd_bad", $urandom_range(16, 30), 0, 0, 0, 0, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
